// File: rtl/tl_c_pkg.sv
// Shared TileLink channel C/D definitions for the release responder.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package tl_c_pkg;

    // Channel C opcodes handled by the manager endpoint
    localparam logic [2:0] C_PROBE_ACK        = 3'd4;
    localparam logic [2:0] C_PROBE_ACK_DATA   = 3'd5;
    localparam logic [2:0] C_RELEASE          = 3'd6;
    localparam logic [2:0] C_RELEASE_DATA     = 3'd7;

    // Channel D opcode returned for every Release/ReleaseData
    localparam logic [2:0] D_RELEASE_ACK      = 3'd6;

    // AMBA prot user bits carried alongside channel C beats
    typedef struct packed {
        logic fetch;
        logic secure;
        logic privileged;
        logic writealloc;
        logic readalloc;
        logic modifiable;
        logic bufferable;
    } amba_prot_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        ACK   = 2'd2
    } state_t;

    // Number of channel C beats a message occupies; dataless messages are one beat
    function automatic logic [15:0] beats_of(input logic [3:0] size,
                                             input logic       has_data,
                                             input int         lg_data);
        logic [15:0] n;
        n = 16'd1;
        if (has_data && (int'(size) > lg_data)) begin
            n = 16'd1 << (int'(size) - lg_data);
        end
        return n;
    endfunction

endpackage

// File: rtl/tl_c_beat_counter.sv
// Beat counter for channel C bursts: tracks beat index, flags the last beat, makes the address offset.
// Latency: last/offset are combinational from the registered count; count updates on the accepting edge.
// Backpressure: count only advances on beat_fire, so a stalled beat holds its index.
module tl_c_beat_counter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_BYTES = 8,
    parameter int CNT_W      = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              beat_fire,
    input  logic [CNT_W-1:0]  beats,
    output logic              last,
    output logic [ADDR_W-1:0] offset
);
    localparam int LG_DATA = $clog2(DATA_BYTES);

    logic [CNT_W-1:0] count;

    // Advance on every accepted beat, wrapping to zero after the final one
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (beat_fire) begin
            count <= last ? '0 : count + CNT_W'(1);
        end
    end

    assign last   = (count == beats - CNT_W'(1));
    assign offset = ADDR_W'(count) << LG_DATA;

endmodule

// File: rtl/tl_c_release_responder.sv
// Channel C manager endpoint: streams data beats to writeback, reports probe acks, answers Releases on D.
// Latency: wb path is zero-latency pass-through; ReleaseAck / probe report / error flag appear the cycle after the last beat.
// Backpressure: c_ready follows wb_ready for data beats and drops while a ReleaseAck waits for d_ready.
module tl_c_release_responder
    import tl_c_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_BYTES = 8,
    parameter int LINE_BYTES = 64,
    parameter int SOURCE_W   = 4,
    parameter int SINK_W     = 2,
    parameter int SINK_ID    = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    c_valid,
    output logic                    c_ready,
    input  logic [2:0]              c_opcode,
    input  logic [2:0]              c_param,
    input  logic [3:0]              c_size,
    input  logic [SOURCE_W-1:0]     c_source,
    input  logic [ADDR_W-1:0]       c_address,
    input  logic [8*DATA_BYTES-1:0] c_data,
    input  logic                    c_corrupt,
    input  logic [6:0]              c_prot,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [ADDR_W-1:0]       wb_addr,
    output logic [8*DATA_BYTES-1:0] wb_data,
    output logic                    wb_last,
    output logic [6:0]              wb_prot,
    output logic                    wb_corrupt,
    output logic                    wb_is_probe,
    output logic                    pack_valid,
    output logic [2:0]              pack_param,
    output logic [SOURCE_W-1:0]     pack_source,
    output logic                    pack_data,
    output logic                    d_valid,
    input  logic                    d_ready,
    output logic [2:0]              d_opcode,
    output logic [1:0]              d_param,
    output logic [3:0]              d_size,
    output logic [SOURCE_W-1:0]     d_source,
    output logic [SINK_W-1:0]       d_sink,
    output logic                    d_denied,
    output logic                    err_pulse
);
    localparam int LG_DATA = $clog2(DATA_BYTES);
    localparam int LG_LINE = $clog2(LINE_BYTES);
    localparam int CNT_W   = $clog2(LINE_BYTES / DATA_BYTES) + 1;

    state_t              state, state_nxt;
    logic [2:0]          lat_opcode, lat_param;
    logic [3:0]          lat_size;
    logic [SOURCE_W-1:0] lat_source;
    logic [ADDR_W-1:0]   lat_address;
    amba_prot_t          lat_prot;

    logic                in_idle, has_data, size_bad, misaligned, mismatch;
    logic                c_fire, beat_fire, last_beat, is_release, latch_en;
    logic [2:0]          cur_opcode;
    logic [3:0]          cur_size;
    logic [CNT_W-1:0]    beats;
    logic [ADDR_W-1:0]   beat_offset, align_mask;
    logic                d_vld_nxt, pack_vld_nxt, err_nxt;

    // First beat is described by the live inputs, later beats by what was latched at burst start
    assign in_idle    = (state == IDLE);
    assign has_data   = c_opcode[0];
    assign cur_opcode = in_idle ? c_opcode : lat_opcode;
    assign cur_size   = in_idle ? c_size : lat_size;
    assign beats      = CNT_W'(beats_of(cur_size, cur_opcode[0], LG_DATA));
    assign is_release = (cur_opcode == C_RELEASE) || (cur_opcode == C_RELEASE_DATA);

    // Oversized first beats are swallowed as one beat with nothing forwarded
    assign size_bad   = in_idle && (c_size > 4'(LG_LINE));
    assign align_mask = (ADDR_W'(1) << c_size) - ADDR_W'(1);
    assign misaligned = |(c_address & align_mask);
    assign mismatch   = (c_opcode != lat_opcode) || (c_source != lat_source) || (c_size != lat_size);

    assign c_ready    = (state != ACK) && (!has_data || wb_ready);
    assign c_fire     = c_valid && c_ready;
    assign beat_fire  = c_fire && !size_bad;

    tl_c_beat_counter #(
        .ADDR_W     (ADDR_W),
        .DATA_BYTES (DATA_BYTES),
        .CNT_W      (CNT_W)
    ) u_beat_counter (
        .clock     (clock),
        .reset     (reset),
        .beat_fire (beat_fire),
        .beats     (beats),
        .last      (last_beat),
        .offset    (beat_offset)
    );

    // Writeback stream is a straight pass-through of channel C
    assign wb_valid    = c_valid && has_data && (state != ACK) && !size_bad;
    assign wb_addr     = in_idle ? c_address : lat_address + beat_offset;
    assign wb_data     = c_data;
    assign wb_last     = last_beat;
    assign wb_prot     = in_idle ? c_prot : lat_prot;
    assign wb_corrupt  = c_corrupt;
    assign wb_is_probe = !cur_opcode[1];

    assign pack_param  = lat_param;
    assign pack_source = lat_source;
    assign pack_data   = lat_opcode[0];

    assign d_opcode    = D_RELEASE_ACK;
    assign d_param     = 2'd0;
    assign d_size      = lat_size;
    assign d_source    = lat_source;
    assign d_sink      = SINK_W'(SINK_ID);
    assign d_denied    = 1'b0;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state, first-beat latch enable and next values of the registered pulses
    always_comb begin
        state_nxt    = state;
        d_vld_nxt    = d_valid;
        pack_vld_nxt = 1'b0;
        err_nxt      = 1'b0;
        latch_en     = 1'b0;
        case (state)
            IDLE: begin
                if (c_fire) begin
                    if (size_bad) begin
                        err_nxt = 1'b1;
                    end else begin
                        latch_en = 1'b1;
                        err_nxt  = misaligned;
                        if (!last_beat)      state_nxt = BURST;
                        else if (is_release) begin
                            state_nxt = ACK;
                            d_vld_nxt = 1'b1;
                        end else             pack_vld_nxt = 1'b1;
                    end
                end
            end
            BURST: begin
                if (c_fire) begin
                    err_nxt = mismatch;
                    if (last_beat) begin
                        if (is_release) begin
                            state_nxt = ACK;
                            d_vld_nxt = 1'b1;
                        end else begin
                            state_nxt    = IDLE;
                            pack_vld_nxt = 1'b1;
                        end
                    end
                end
            end
            ACK: begin
                if (d_ready) begin
                    state_nxt = IDLE;
                    d_vld_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered handshake outputs and first-beat message fields
    always_ff @(posedge clock) begin
        if (reset) begin
            d_valid     <= 1'b0;
            pack_valid  <= 1'b0;
            err_pulse   <= 1'b0;
            lat_opcode  <= '0;
            lat_param   <= '0;
            lat_size    <= '0;
            lat_source  <= '0;
            lat_address <= '0;
            lat_prot    <= '0;
        end else begin
            d_valid    <= d_vld_nxt;
            pack_valid <= pack_vld_nxt;
            err_pulse  <= err_nxt;
            if (latch_en) begin
                lat_opcode  <= c_opcode;
                lat_param   <= c_param;
                lat_size    <= c_size;
                lat_source  <= c_source;
                lat_address <= c_address;
                lat_prot    <= amba_prot_t'(c_prot);
            end
        end
    end

endmodule

// File: tb/tb_tl_c_release_responder.sv
module tb_tl_c_release_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        c_valid, c_ready;
    logic [2:0]  c_opcode, c_param;
    logic [3:0]  c_size;
    logic [3:0]  c_source;
    logic [31:0] c_address;
    logic [63:0] c_data;
    logic        c_corrupt;
    logic [6:0]  c_prot;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_addr;
    logic [63:0] wb_data;
    logic        wb_last, wb_corrupt, wb_is_probe;
    logic [6:0]  wb_prot;
    logic        pack_valid, pack_data;
    logic [2:0]  pack_param;
    logic [3:0]  pack_source;
    logic        d_valid, d_ready, d_denied;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param, d_sink;
    logic [3:0]  d_size, d_source;
    logic        err_pulse;

    int vec_cnt = 0;
    int miss_cnt = 0;

    always #5 clock = ~clock;

    tl_c_release_responder dut (
        .clock(clock), .reset(reset),
        .c_valid(c_valid), .c_ready(c_ready), .c_opcode(c_opcode), .c_param(c_param),
        .c_size(c_size), .c_source(c_source), .c_address(c_address), .c_data(c_data),
        .c_corrupt(c_corrupt), .c_prot(c_prot),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_last(wb_last), .wb_prot(wb_prot), .wb_corrupt(wb_corrupt), .wb_is_probe(wb_is_probe),
        .pack_valid(pack_valid), .pack_param(pack_param), .pack_source(pack_source), .pack_data(pack_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
        .err_pulse(err_pulse)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vec_cnt);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_c(input logic v, input logic [2:0] op, input logic [2:0] prm,
                           input logic [3:0] sz, input logic [3:0] src, input logic [31:0] addr,
                           input logic [63:0] dat, input logic [6:0] prot);
        c_valid = v; c_opcode = op; c_param = prm; c_size = sz; c_source = src;
        c_address = addr; c_data = dat; c_prot = prot; c_corrupt = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; wb_ready = 1'b1; d_ready = 1'b1;
        drive_c(1'b0, 3'd0, 3'd0, 4'd0, 4'd0, 32'd0, 64'd0, 7'd0);
        step(); step();
        reset = 1'b0;
        step();
        vec_cnt++;
        if ({d_valid, pack_valid, err_pulse, wb_valid} !== 4'b0000) begin
            miss_cnt++;
            $display("FAIL reset_outputs: got d/pack/err/wb=%b want 0000", {d_valid, pack_valid, err_pulse, wb_valid});
        end
        vec_cnt++;
        if (c_ready !== 1'b1 || d_size !== 4'd0 || d_source !== 4'd0) begin
            miss_cnt++;
            $display("FAIL reset_state: got c_ready=%b d_size=%0d d_source=%0d want 1 0 0", c_ready, d_size, d_source);
        end
    endtask

    task automatic test_release_single();
        drive_c(1'b1, 3'd6, 3'd1, 4'd6, 4'd3, 32'h8000_0040, 64'd0, 7'd0);
        #1;
        vec_cnt++;
        if (c_ready !== 1'b1 || wb_valid !== 1'b0) begin
            miss_cnt++;
            $display("FAIL rel_accept: got c_ready=%b wb_valid=%b want 1 0", c_ready, wb_valid);
        end
        step();
        c_valid = 1'b0;
        vec_cnt++;
        if (d_valid !== 1'b1 || d_opcode !== 3'd6 || d_source !== 4'd3 || d_size !== 4'd6 ||
            d_param !== 2'd0 || d_sink !== 2'd0 || d_denied !== 1'b0) begin
            miss_cnt++;
            $display("FAIL rel_dresp: got v=%b op=%0d src=%0d sz=%0d prm=%0d sink=%0d den=%b want 1 6 3 6 0 0 0",
                     d_valid, d_opcode, d_source, d_size, d_param, d_sink, d_denied);
        end
        vec_cnt++;
        if (c_ready !== 1'b0 || err_pulse !== 1'b0) begin
            miss_cnt++;
            $display("FAIL rel_ack_state: got c_ready=%b err=%b want 0 0", c_ready, err_pulse);
        end
        step();
        vec_cnt++;
        if (d_valid !== 1'b0 || c_ready !== 1'b1) begin
            miss_cnt++;
            $display("FAIL rel_done: got d_valid=%b c_ready=%b want 0 1", d_valid, c_ready);
        end
    endtask

    task automatic test_release_data();
        for (int i = 0; i < 8; i++) begin
            drive_c(1'b1, 3'd7, 3'd0, 4'd6, 4'd5, 32'h8000_0040, 64'hA000 + 64'(i),
                    (i == 0) ? 7'h12 : 7'h00);
            #1;
            vec_cnt++;
            if (wb_valid !== 1'b1 || c_ready !== 1'b1 || wb_addr !== 32'h8000_0040 + 32'(i * 8) ||
                wb_last !== (i == 7) || wb_prot !== 7'h12 || wb_data !== 64'hA000 + 64'(i) ||
                wb_is_probe !== 1'b0) begin
                miss_cnt++;
                $display("FAIL reldata_beat%0d: got v=%b rdy=%b addr=%h last=%b prot=%h data=%h probe=%b want 1 1 %h %b 12 %h 0",
                         i, wb_valid, c_ready, wb_addr, wb_last, wb_prot, wb_data, wb_is_probe,
                         32'h8000_0040 + 32'(i * 8), (i == 7), 64'hA000 + 64'(i));
            end
            step();
            if (i < 7) begin
                vec_cnt++;
                if (d_valid !== 1'b0) begin
                    miss_cnt++;
                    $display("FAIL reldata_early_d: beat %0d got d_valid=%b want 0", i, d_valid);
                end
            end
        end
        c_valid = 1'b0;
        vec_cnt++;
        if (d_valid !== 1'b1 || d_source !== 4'd5 || d_size !== 4'd6 || pack_valid !== 1'b0) begin
            miss_cnt++;
            $display("FAIL reldata_dresp: got v=%b src=%0d sz=%0d pack=%b want 1 5 6 0", d_valid, d_source, d_size, pack_valid);
        end
        step();
        vec_cnt++;
        if (d_valid !== 1'b0) begin
            miss_cnt++;
            $display("FAIL reldata_done: got d_valid=%b want 0", d_valid);
        end
    endtask

    task automatic test_probe_ack();
        drive_c(1'b1, 3'd4, 3'd3, 4'd6, 4'd1, 32'h0000_0800, 64'd0, 7'd0);
        step();
        c_valid = 1'b0;
        vec_cnt++;
        if (pack_valid !== 1'b1 || pack_data !== 1'b0 || pack_param !== 3'd3 || pack_source !== 4'd1 || d_valid !== 1'b0) begin
            miss_cnt++;
            $display("FAIL probeack_report: got v=%b data=%b prm=%0d src=%0d d=%b want 1 0 3 1 0",
                     pack_valid, pack_data, pack_param, pack_source, d_valid);
        end
        step();
        vec_cnt++;
        if (pack_valid !== 1'b0) begin
            miss_cnt++;
            $display("FAIL probeack_pulse: got pack_valid=%b want 0", pack_valid);
        end
    endtask

    task automatic test_probe_data();
        int beat = 0;
        int cyc = 0;
        int pack_cnt = 0;
        while (beat < 8 && cyc < 40) begin
            wb_ready = (cyc % 2 == 0);
            drive_c(1'b1, 3'd5, 3'd1, 4'd6, 4'd2, 32'h0000_1000, 64'hB000 + 64'(beat), 7'h05);
            #1;
            if (wb_ready) begin
                vec_cnt++;
                if (wb_valid !== 1'b1 || c_ready !== 1'b1 || wb_addr !== 32'h0000_1000 + 32'(beat * 8) ||
                    wb_last !== (beat == 7) || wb_is_probe !== 1'b1 || wb_data !== 64'hB000 + 64'(beat)) begin
                    miss_cnt++;
                    $display("FAIL probedata_beat%0d: got v=%b rdy=%b addr=%h last=%b probe=%b data=%h",
                             beat, wb_valid, c_ready, wb_addr, wb_last, wb_is_probe, wb_data);
                end
            end else begin
                vec_cnt++;
                if (c_ready !== 1'b0 || wb_valid !== 1'b1) begin
                    miss_cnt++;
                    $display("FAIL probedata_stall%0d: got c_ready=%b wb_valid=%b want 0 1", beat, c_ready, wb_valid);
                end
            end
            step();
            if (wb_ready) beat++;
            cyc++;
            if (pack_valid === 1'b1) pack_cnt++;
        end
        vec_cnt++;
        if (beat != 8) begin
            miss_cnt++;
            $display("FAIL probedata_beats: got %0d beats want 8", beat);
        end
        vec_cnt++;
        if (pack_valid !== 1'b1 || pack_data !== 1'b1 || pack_source !== 4'd2 || pack_param !== 3'd1) begin
            miss_cnt++;
            $display("FAIL probedata_report: got v=%b data=%b src=%0d prm=%0d want 1 1 2 1",
                     pack_valid, pack_data, pack_source, pack_param);
        end
        c_valid = 1'b0;
        wb_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (pack_valid === 1'b1) pack_cnt++;
            vec_cnt++;
            if (d_valid !== 1'b0) begin
                miss_cnt++;
                $display("FAIL probedata_no_d: got d_valid=%b want 0", d_valid);
            end
        end
        vec_cnt++;
        if (pack_cnt != 1) begin
            miss_cnt++;
            $display("FAIL probedata_pulses: got %0d pack pulses want 1", pack_cnt);
        end
    endtask

    task automatic test_back_to_back();
        d_ready = 1'b0;
        drive_c(1'b1, 3'd6, 3'd0, 4'd3, 4'd9, 32'h0000_0200, 64'd0, 7'd0);
        step();
        drive_c(1'b1, 3'd6, 3'd0, 4'd6, 4'd4, 32'h0000_0400, 64'd0, 7'd0);
        for (int k = 0; k < 5; k++) begin
            #1;
            vec_cnt++;
            if (d_valid !== 1'b1 || d_source !== 4'd9 || d_size !== 4'd3 || c_ready !== 1'b0) begin
                miss_cnt++;
                $display("FAIL b2b_hold%0d: got v=%b src=%0d sz=%0d c_ready=%b want 1 9 3 0",
                         k, d_valid, d_source, d_size, c_ready);
            end
            step();
        end
        d_ready = 1'b1;
        #1;
        vec_cnt++;
        if (c_ready !== 1'b0) begin
            miss_cnt++;
            $display("FAIL b2b_handshake_cycle: got c_ready=%b want 0", c_ready);
        end
        step();
        vec_cnt++;
        if (d_valid !== 1'b0 || c_ready !== 1'b1) begin
            miss_cnt++;
            $display("FAIL b2b_after: got d_valid=%b c_ready=%b want 0 1", d_valid, c_ready);
        end
        step();
        c_valid = 1'b0;
        vec_cnt++;
        if (d_valid !== 1'b1 || d_source !== 4'd4 || d_size !== 4'd6) begin
            miss_cnt++;
            $display("FAIL b2b_second: got v=%b src=%0d sz=%0d want 1 4 6", d_valid, d_source, d_size);
        end
        step();
    endtask

    task automatic test_size_error();
        drive_c(1'b1, 3'd7, 3'd0, 4'd7, 4'd6, 32'h0000_0000, 64'hDEAD, 7'd0);
        #1;
        vec_cnt++;
        if (wb_valid !== 1'b0 || c_ready !== 1'b1) begin
            miss_cnt++;
            $display("FAIL size7_accept: got wb_valid=%b c_ready=%b want 0 1", wb_valid, c_ready);
        end
        step();
        c_valid = 1'b0;
        vec_cnt++;
        if (err_pulse !== 1'b1 || d_valid !== 1'b0 || pack_valid !== 1'b0) begin
            miss_cnt++;
            $display("FAIL size7_err: got err=%b d=%b pack=%b want 1 0 0", err_pulse, d_valid, pack_valid);
        end
        step();
        vec_cnt++;
        if (err_pulse !== 1'b0 || d_valid !== 1'b0 || c_ready !== 1'b1) begin
            miss_cnt++;
            $display("FAIL size7_idle: got err=%b d=%b c_ready=%b want 0 0 1", err_pulse, d_valid, c_ready);
        end
        drive_c(1'b1, 3'd6, 3'd0, 4'd6, 4'd8, 32'h0000_0048, 64'd0, 7'd0);
        step();
        c_valid = 1'b0;
        vec_cnt++;
        if (err_pulse !== 1'b1 || d_valid !== 1'b1 || d_source !== 4'd8) begin
            miss_cnt++;
            $display("FAIL misalign: got err=%b d=%b src=%0d want 1 1 8", err_pulse, d_valid, d_source);
        end
        step();
    endtask

    task automatic test_burst_mismatch();
        drive_c(1'b1, 3'd7, 3'd0, 4'd4, 4'd2, 32'h0000_0300, 64'h1, 7'd0);
        #1;
        vec_cnt++;
        if (wb_last !== 1'b0) begin
            miss_cnt++;
            $display("FAIL mismatch_first_last: got wb_last=%b want 0", wb_last);
        end
        step();
        drive_c(1'b1, 3'd7, 3'd0, 4'd4, 4'd3, 32'h0000_0300, 64'h2, 7'd0);
        #1;
        vec_cnt++;
        if (wb_valid !== 1'b1 || wb_last !== 1'b1 || wb_addr !== 32'h0000_0308 || err_pulse !== 1'b0) begin
            miss_cnt++;
            $display("FAIL mismatch_beat2: got v=%b last=%b addr=%h err=%b want 1 1 308 0", wb_valid, wb_last, wb_addr, err_pulse);
        end
        step();
        c_valid = 1'b0;
        vec_cnt++;
        if (err_pulse !== 1'b1 || d_valid !== 1'b1 || d_source !== 4'd2 || d_size !== 4'd4) begin
            miss_cnt++;
            $display("FAIL mismatch_err: got err=%b d=%b src=%0d sz=%0d want 1 1 2 4", err_pulse, d_valid, d_source, d_size);
        end
        step();
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 3; i++) begin
            drive_c(1'b1, 3'd7, 3'd0, 4'd6, 4'd5, 32'h0000_2000, 64'(i), 7'd0);
            step();
        end
        drive_c(1'b1, 3'd7, 3'd0, 4'd6, 4'd5, 32'h0000_2000, 64'd3, 7'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        c_valid = 1'b0;
        #1;
        vec_cnt++;
        if (wb_valid !== 1'b0 || d_valid !== 1'b0 || c_ready !== 1'b1) begin
            miss_cnt++;
            $display("FAIL rst_mid: got wb_valid=%b d_valid=%b c_ready=%b want 0 0 1", wb_valid, d_valid, c_ready);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            vec_cnt++;
            if (d_valid !== 1'b0 || wb_valid !== 1'b0) begin
                miss_cnt++;
                $display("FAIL rst_quiet%0d: got d_valid=%b wb_valid=%b want 0 0", k, d_valid, wb_valid);
            end
        end
        drive_c(1'b1, 3'd6, 3'd0, 4'd6, 4'd7, 32'h0000_3000, 64'd0, 7'd0);
        step();
        c_valid = 1'b0;
        vec_cnt++;
        if (d_valid !== 1'b1 || d_source !== 4'd7 || d_size !== 4'd6 || err_pulse !== 1'b0) begin
            miss_cnt++;
            $display("FAIL rst_fresh: got d=%b src=%0d sz=%0d err=%b want 1 7 6 0", d_valid, d_source, d_size, err_pulse);
        end
        step();
        vec_cnt++;
        if (d_valid !== 1'b0) begin
            miss_cnt++;
            $display("FAIL rst_fresh_done: got d_valid=%b want 0", d_valid);
        end
    endtask

    initial begin
        test_reset();
        test_release_single();
        test_release_data();
        test_probe_ack();
        test_probe_data();
        test_back_to_back();
        test_size_error();
        test_burst_mismatch();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
